// File: rtl/alu_muldiv.sv
// MIPS EX-stage ALU with iterative multiply/divide and HI/LO registers.
// Optional signed add/sub overflow flag: define ALU_OVERFLOW_TRAP_EN.
module alu_muldiv #(
  parameter int CANT_BITS_ALU_CONTROL = 5,
  parameter int CANT_BITS_DATO        = 32
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic [CANT_BITS_ALU_CONTROL-1:0] i_ALUCtrl,
  input  logic [CANT_BITS_DATO-1:0]        i_datoA,
  input  logic [CANT_BITS_DATO-1:0]        i_datoB,
  input  logic                             i_valid,
  output logic [CANT_BITS_DATO-1:0]        o_resultado,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_overflow
);
  localparam int W               = CANT_BITS_DATO;
  localparam int CANT_BITS_SHAMT = $clog2(CANT_BITS_DATO);
  localparam int CNT_W           = $clog2(CANT_BITS_DATO) + 1;
  localparam int CW              = CANT_BITS_ALU_CONTROL;

  localparam logic [CW-1:0] OP_AND   = CW'(5'b00000);
  localparam logic [CW-1:0] OP_OR    = CW'(5'b00001);
  localparam logic [CW-1:0] OP_ADDU  = CW'(5'b00010);
  localparam logic [CW-1:0] OP_ADD   = CW'(5'b00011);
  localparam logic [CW-1:0] OP_SUB   = CW'(5'b00100);
  localparam logic [CW-1:0] OP_SLTU  = CW'(5'b00101);
  localparam logic [CW-1:0] OP_SUBU  = CW'(5'b00110);
  localparam logic [CW-1:0] OP_SLT   = CW'(5'b00111);
  localparam logic [CW-1:0] OP_LUI   = CW'(5'b01000);
  localparam logic [CW-1:0] OP_XOR   = CW'(5'b01001);
  localparam logic [CW-1:0] OP_NOR   = CW'(5'b01010);
  localparam logic [CW-1:0] OP_SLL   = CW'(5'b01011);
  localparam logic [CW-1:0] OP_SRL   = CW'(5'b01100);
  localparam logic [CW-1:0] OP_SRA   = CW'(5'b01101);
  localparam logic [CW-1:0] OP_PASS  = CW'(5'b01110);
  localparam logic [CW-1:0] OP_MULT  = CW'(5'b10000);
  localparam logic [CW-1:0] OP_MULTU = CW'(5'b10001);
  localparam logic [CW-1:0] OP_DIV   = CW'(5'b10010);
  localparam logic [CW-1:0] OP_DIVU  = CW'(5'b10011);
  localparam logic [CW-1:0] OP_MFHI  = CW'(5'b10100);
  localparam logic [CW-1:0] OP_MFLO  = CW'(5'b10101);
  localparam logic [CW-1:0] OP_MTHI  = CW'(5'b10110);
  localparam logic [CW-1:0] OP_MTLO  = CW'(5'b10111);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]     accHi_q, accHi_d, accLo_q, accLo_d, opnd_q, opnd_d;
  logic             negRes_q, negRes_d, negRem_q, negRem_d;
  logic             divZero_q, divZero_d, isDiv_q, isDiv_d;

  logic             isIter, isSigned, signA, signB, idle;
  logic [W-1:0]     absA, absB, quotFix, remFix, divDiff;
  logic [W:0]       mulSum, divShift;
  logic             noBorrow;
  logic [2*W-1:0]   prod, prodFix;
  logic [CANT_BITS_SHAMT-1:0] shamt;

  assign idle     = (state_q == S_IDLE);
  assign isIter   = (i_ALUCtrl == OP_MULT) || (i_ALUCtrl == OP_MULTU) ||
                    (i_ALUCtrl == OP_DIV)  || (i_ALUCtrl == OP_DIVU);
  assign isSigned = (i_ALUCtrl == OP_MULT) || (i_ALUCtrl == OP_DIV);
  assign signA    = isSigned & i_datoA[W-1];
  assign signB    = isSigned & i_datoB[W-1];
  assign absA     = signA ? -i_datoA : i_datoA;
  assign absB     = signB ? -i_datoB : i_datoB;
  assign shamt    = i_datoB[CANT_BITS_SHAMT-1:0];

  // Shift-add step: multiplier sits in accLo and shifts out as the product shifts in.
  assign mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : '0);
  // Restoring step: dividend bits shift from accLo into the partial remainder in accHi.
  assign divShift = {accHi_q, accLo_q[W-1]};
  assign noBorrow = (divShift >= {1'b0, opnd_q});
  assign divDiff  = divShift[W-1:0] - opnd_q;

  assign prod     = {accHi_q, accLo_q};
  assign prodFix  = negRes_q ? -prod : prod;
  // A zero divisor keeps the all-ones quotient unsigned; the remainder then equals the dividend.
  assign quotFix  = (negRes_q && !divZero_q) ? -accLo_q : accLo_q;
  assign remFix   = negRem_q ? -accHi_q : accHi_q;

  assign o_busy   = !idle;
  assign o_done   = (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    accHi_d   = accHi_q;
    accLo_d   = accLo_q;
    opnd_d    = opnd_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    isDiv_d   = isDiv_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid && isIter) begin
          cnt_d     = CNT_W'(W);
          negRes_d  = signA ^ signB;
          negRem_d  = signA;
          accHi_d   = '0;
          if (i_ALUCtrl == OP_MULT || i_ALUCtrl == OP_MULTU) begin
            state_d = S_MUL;
            isDiv_d = 1'b0;
            accLo_d = absB;
            opnd_d  = absA;
          end else begin
            state_d   = S_DIV;
            isDiv_d   = 1'b1;
            accLo_d   = absA;
            opnd_d    = absB;
            divZero_d = (i_datoB == '0);
          end
        end else if (i_valid && i_ALUCtrl == OP_MTHI) begin
          hi_d = i_datoA;
        end else if (i_valid && i_ALUCtrl == OP_MTLO) begin
          lo_d = i_datoA;
        end
      end
      S_MUL: begin
        accHi_d = mulSum[W:1];
        accLo_d = {mulSum[0], accLo_q[W-1:1]};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DIV: begin
        accHi_d = noBorrow ? divDiff : divShift[W-1:0];
        accLo_d = {accLo_q[W-2:0], noBorrow};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        if (isDiv_q) begin
          hi_d = remFix;
          lo_d = quotFix;
        end else begin
          hi_d = prodFix[2*W-1:W];
          lo_d = prodFix[W-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      opnd_q    <= '0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      isDiv_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      accHi_q   <= accHi_d;
      accLo_q   <= accLo_d;
      opnd_q    <= opnd_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      isDiv_q   <= isDiv_d;
    end
  end

  always_comb begin
    o_resultado = i_datoA + i_datoB;
    case (i_ALUCtrl)
      OP_SLL:   o_resultado = i_datoA << shamt;
      OP_SRL:   o_resultado = i_datoA >> shamt;
      OP_SRA:   o_resultado = $unsigned($signed(i_datoA) >>> shamt);
      OP_SUB, OP_SUBU: o_resultado = i_datoA - i_datoB;
      OP_AND:   o_resultado = i_datoA & i_datoB;
      OP_OR:    o_resultado = i_datoA | i_datoB;
      OP_XOR:   o_resultado = i_datoA ^ i_datoB;
      OP_NOR:   o_resultado = ~(i_datoA | i_datoB);
      OP_SLT:   o_resultado = {{(W-1){1'b0}}, ($signed(i_datoA) < $signed(i_datoB))};
      OP_SLTU:  o_resultado = {{(W-1){1'b0}}, (i_datoA < i_datoB)};
      OP_LUI:   o_resultado = i_datoB << (W/2);
      OP_PASS, OP_MTHI, OP_MTLO: o_resultado = i_datoA;
      OP_MFHI:  o_resultado = hi_q;
      OP_MFLO:  o_resultado = lo_q;
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: o_resultado = '0;
      default:  o_resultado = i_datoA + i_datoB;
    endcase
  end

`ifdef ALU_OVERFLOW_TRAP_EN
  logic [W-1:0] addRes, subRes;
  assign addRes = i_datoA + i_datoB;
  assign subRes = i_datoA - i_datoB;
  always_comb begin
    o_overflow = 1'b0;
    if (i_ALUCtrl == OP_ADD)
      o_overflow = (i_datoA[W-1] == i_datoB[W-1]) && (addRes[W-1] != i_datoA[W-1]);
    else if (i_ALUCtrl == OP_SUB)
      o_overflow = (i_datoA[W-1] != i_datoB[W-1]) && (subRes[W-1] != i_datoA[W-1]);
  end
`else
  assign o_overflow = 1'b0;
`endif

endmodule
